// File: rtl/parc_core_sb_pkg.sv
// Shared constants and the completion-pipe entry type for the PARC issue scoreboard.
// Optional completion bypass is enabled with the PARC_SB_BYPASS_EN macro.
package parc_core_sb_pkg;
  localparam int SLOT_W       = 4;
  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int LONG_LAT_DEF = 4;

  typedef struct packed {
    logic              val;
    logic [SLOT_W-1:0] slot;
  } wb_entry_t;
endpackage

// File: rtl/parc_core_sb_wb_pipe.sv
// Completion shift register: entries enter at stage lat and drain through stage 1,
// which drives the single ROB fill port. Also reports writeback-port conflicts.
module parc_core_sb_wb_pipe
  import parc_core_sb_pkg::*;
#(
  parameter int LONG_LAT = LONG_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ins_val,
  input  logic [2:0]        i_ins_lat,
  input  logic [SLOT_W-1:0] i_ins_slot,
  output logic              o_conflict,
  output logic              o_fill_val,
  output logic [SLOT_W-1:0] o_fill_slot
);
  wb_entry_t r_pipe [1:LONG_LAT];
  // w_up[i] is what stage i inherits this cycle (stage i+1, or empty above the top).
  wb_entry_t w_up   [1:LONG_LAT];

  genvar gi;
  generate
    for (gi = 1; gi <= LONG_LAT; gi++) begin : g_up
      if (gi == LONG_LAT) begin : g_top
        assign w_up[gi] = '0;
      end else begin : g_mid
        assign w_up[gi] = r_pipe[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 1; i <= LONG_LAT; i++) begin
      if (!reset)
        r_pipe[i] <= '0;
      else if (i_ins_val && (int'(i_ins_lat) == i))
        r_pipe[i] <= {1'b1, i_ins_slot};
      else
        r_pipe[i] <= w_up[i];
    end
  end

  // A new entry at stage lat collides with whatever shifts down into that stage.
  always_comb begin
    o_conflict = 1'b0;
    for (int i = 1; i < LONG_LAT; i++) begin
      if ((int'(i_ins_lat) == i) && w_up[i].val)
        o_conflict = 1'b1;
    end
  end

  assign o_fill_val  = r_pipe[1].val;
  assign o_fill_slot = r_pipe[1].slot;
endmodule

// File: rtl/parc_core_issue_scoreboard.sv
// In-order issue scoreboard: RAW / writeback-port / ROB-space checks, per-register pending table.
// Define PARC_SB_BYPASS_EN to let completed-but-uncommitted results issue via the bypass network.
module parc_core_issue_scoreboard
  import parc_core_sb_pkg::REG_W, parc_core_sb_pkg::NUM_REGS;
#(
  parameter int LONG_LAT = parc_core_sb_pkg::LONG_LAT_DEF,
  parameter int SLOT_W   = parc_core_sb_pkg::SLOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_val,
  output logic              issue_rdy,
  input  logic              issue_long,
  input  logic              src0_en,
  input  logic [REG_W-1:0]  src0_addr,
  input  logic              src1_en,
  input  logic [REG_W-1:0]  src1_addr,
  input  logic              dst_en,
  input  logic [REG_W-1:0]  dst_addr,
  output logic              src0_byp,
  output logic              src1_byp,
  output logic              rob_alloc_req_val,
  input  logic              rob_alloc_req_rdy,
  output logic [REG_W-1:0]  rob_alloc_req_preg,
  input  logic [SLOT_W-1:0] rob_alloc_resp_slot,
  output logic              rob_fill_val,
  output logic [SLOT_W-1:0] rob_fill_slot,
  input  logic              rob_commit_wen,
  input  logic [SLOT_W-1:0] rob_commit_slot,
  input  logic [REG_W-1:0]  rob_commit_rf_waddr
);
  logic              r_pending [NUM_REGS];
  logic [SLOT_W-1:0] r_tag     [NUM_REGS];
  logic [2:0]        r_cnt     [NUM_REGS];

  logic [2:0] w_lat;
  logic       w_dst, w_pend0, w_pend1, w_raw0, w_raw1, w_byp0, w_byp1;
  logic       w_wbc, w_ok, w_fire_dst, w_fill_val;

  assign w_lat   = issue_long ? 3'(LONG_LAT) : 3'd1;
  assign w_dst   = dst_en && (dst_addr != '0);
  assign w_pend0 = src0_en && (src0_addr != '0) && r_pending[src0_addr];
  assign w_pend1 = src1_en && (src1_addr != '0) && r_pending[src1_addr];

`ifdef PARC_SB_BYPASS_EN
  // cnt==0 means the value has already been broadcast on the fill port.
  assign w_raw0 = w_pend0 && (r_cnt[src0_addr] != 3'd0);
  assign w_raw1 = w_pend1 && (r_cnt[src1_addr] != 3'd0);
  assign w_byp0 = w_pend0 && (r_cnt[src0_addr] == 3'd0);
  assign w_byp1 = w_pend1 && (r_cnt[src1_addr] == 3'd0);
`else
  assign w_raw0 = w_pend0;
  assign w_raw1 = w_pend1;
  assign w_byp0 = 1'b0;
  assign w_byp1 = 1'b0;
`endif

  assign w_ok       = !w_raw0 && !w_raw1 && !w_wbc;
  assign issue_rdy  = reset && w_ok && (!w_dst || rob_alloc_req_rdy);
  assign w_fire_dst = issue_val && issue_rdy && w_dst;

  assign rob_alloc_req_val  = reset && issue_val && w_dst && w_ok;
  assign rob_alloc_req_preg = dst_addr;
  assign src0_byp           = reset && w_byp0;
  assign src1_byp           = reset && w_byp1;
  assign rob_fill_val       = reset && w_fill_val;

  // A same-cycle issue to a register wins over a commit of its older writer.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (!reset || (r == 0)) begin
        r_pending[r] <= 1'b0;
        r_tag[r]     <= '0;
        r_cnt[r]     <= 3'd0;
      end else if (w_fire_dst && (dst_addr == REG_W'(r))) begin
        r_pending[r] <= 1'b1;
        r_tag[r]     <= rob_alloc_resp_slot;
        r_cnt[r]     <= w_lat;
      end else begin
        if (rob_commit_wen && r_pending[r] && (rob_commit_rf_waddr == REG_W'(r))
            && (r_tag[r] == rob_commit_slot))
          r_pending[r] <= 1'b0;
        if (r_cnt[r] != 3'd0)
          r_cnt[r] <= r_cnt[r] - 3'd1;
      end
    end
  end

  parc_core_sb_wb_pipe #(.LONG_LAT(LONG_LAT)) u_wb_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_ins_val   (w_fire_dst),
    .i_ins_lat   (w_lat),
    .i_ins_slot  (rob_alloc_resp_slot),
    .o_conflict  (w_wbc),
    .o_fill_val  (w_fill_val),
    .o_fill_slot (rob_fill_slot)
  );
endmodule

// File: tb/tb_parc_core_issue_scoreboard.sv
// Directed cycle-by-cycle vectors for the issue scoreboard, plus hand sequences for
// long-latency fill timing and reset with in-flight completions.
module tb_parc_core_issue_scoreboard;
`ifdef PARC_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, issue_val, issue_rdy, issue_long;
  logic       src0_en, src1_en, dst_en, src0_byp, src1_byp;
  logic [4:0] src0_addr, src1_addr, dst_addr, rob_alloc_req_preg, rob_commit_rf_waddr;
  logic       rob_alloc_req_val, rob_alloc_req_rdy, rob_fill_val, rob_commit_wen;
  logic [3:0] rob_alloc_resp_slot, rob_fill_slot, rob_commit_slot;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  parc_core_issue_scoreboard dut (
    .clk(clk), .reset(reset), .issue_val(issue_val), .issue_rdy(issue_rdy),
    .issue_long(issue_long), .src0_en(src0_en), .src0_addr(src0_addr),
    .src1_en(src1_en), .src1_addr(src1_addr), .dst_en(dst_en), .dst_addr(dst_addr),
    .src0_byp(src0_byp), .src1_byp(src1_byp), .rob_alloc_req_val(rob_alloc_req_val),
    .rob_alloc_req_rdy(rob_alloc_req_rdy), .rob_alloc_req_preg(rob_alloc_req_preg),
    .rob_alloc_resp_slot(rob_alloc_resp_slot), .rob_fill_val(rob_fill_val),
    .rob_fill_slot(rob_fill_slot), .rob_commit_wen(rob_commit_wen),
    .rob_commit_slot(rob_commit_slot), .rob_commit_rf_waddr(rob_commit_rf_waddr)
  );

  typedef struct {
    bit rst, val, lng;
    logic [4:0] s0a, s1a;
    bit de;
    logic [4:0] da;
    bit arr;
    logic [3:0] aslot;
    bit cw;
    logic [3:0] cslot;
    logic [4:0] cwa;
    bit rdy, aval, fval;
    logic [3:0] fslot;
    bit b0, b1;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t V(input bit rst, val, lng, input int s0a, s1a, input bit de,
                             input int da, input bit arr, input int aslot, input bit cw,
                             input int cslot, cwa, input bit rdy, aval, fval,
                             input int fslot, input bit b0, b1);
    vec_t x;
    x.rst = rst; x.val = val; x.lng = lng; x.s0a = 5'(s0a); x.s1a = 5'(s1a);
    x.de = de; x.da = 5'(da); x.arr = arr; x.aslot = 4'(aslot); x.cw = cw;
    x.cslot = 4'(cslot); x.cwa = 5'(cwa); x.rdy = rdy; x.aval = aval; x.fval = fval;
    x.fslot = 4'(fslot); x.b0 = b0; x.b1 = b1;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    reset = x.rst; issue_val = x.val; issue_long = x.lng;
    src0_en = (x.s0a != 0); src0_addr = x.s0a;
    src1_en = (x.s1a != 0); src1_addr = x.s1a;
    dst_en = x.de; dst_addr = x.da;
    rob_alloc_req_rdy = x.arr; rob_alloc_resp_slot = x.aslot;
    rob_commit_wen = x.cw; rob_commit_slot = x.cslot; rob_commit_rf_waddr = x.cwa;
  endtask

  task automatic idle();
    apply(V(1,0,0, 0,0, 0,0, 1,0, 0,0,0, 0,0,0,0,0,0));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit lng, input int da, input int slot);
    apply(V(1,1,lng, 0,0, 1,da, 1,slot, 0,0,0, 0,0,0,0,0,0));
  endtask

  initial begin : main
    int k;
    // reset, RAW, alloc back-pressure, wbc, WAW, in stream order
    vecs[0]  = V(0,0,0, 0,0, 0,0,  1,0, 0,0,0, 0,0,0,0,0,0);
    vecs[1]  = V(0,1,0, 0,0, 1,3,  1,0, 0,0,0, 0,0,0,0,0,0);
    vecs[2]  = V(1,1,0, 3,0, 0,0,  1,0, 0,0,0, 1,0,0,0,0,0);
    vecs[3]  = V(1,1,0, 0,0, 1,3,  1,0, 0,0,0, 1,1,0,0,0,0);
    vecs[4]  = V(1,1,0, 3,0, 0,0,  1,0, 0,0,0, 0,0,1,0,0,0);
    vecs[5]  = V(1,1,0, 3,0, 0,0,  1,0, 0,0,0, BYP,0,0,0,BYP,0);
    vecs[6]  = V(1,1,0, 3,0, 0,0,  1,0, 1,0,3, BYP,0,0,0,BYP,0);
    vecs[7]  = V(1,1,0, 3,0, 0,0,  1,0, 0,0,0, 1,0,0,0,0,0);
    vecs[8]  = V(1,1,0, 0,0, 1,7,  0,0, 0,0,0, 0,1,0,0,0,0);
    vecs[9]  = V(1,1,0, 0,0, 0,7,  0,0, 0,0,0, 1,0,0,0,0,0);
    vecs[10] = V(1,1,0, 0,0, 1,0,  0,0, 0,0,0, 1,0,0,0,0,0);
    vecs[11] = V(1,1,1, 0,0, 1,9,  1,1, 0,0,0, 1,1,0,0,0,0);
    vecs[12] = V(1,0,0, 0,0, 0,0,  1,0, 0,0,0, 1,0,0,0,0,0);
    vecs[13] = V(1,1,0, 0,0, 1,10, 1,2, 0,0,0, 1,1,0,0,0,0);
    vecs[14] = V(1,1,0, 0,0, 1,11, 1,3, 0,0,0, 0,0,1,2,0,0);
    vecs[15] = V(1,0,0, 0,0, 0,0,  1,0, 0,0,0, 1,0,1,1,0,0);
    vecs[16] = V(1,0,0, 0,0, 0,0,  1,0, 0,0,0, 1,0,0,0,0,0);
    vecs[17] = V(1,1,0, 0,0, 1,5,  1,2, 0,0,0, 1,1,0,0,0,0);
    vecs[18] = V(1,1,0, 0,0, 1,5,  1,3, 0,0,0, 1,1,1,2,0,0);
    vecs[19] = V(1,1,0, 0,5, 0,0,  1,0, 1,2,5, 0,0,1,3,0,0);
    vecs[20] = V(1,1,0, 0,5, 0,0,  1,0, 1,3,5, BYP,0,0,0,0,BYP);
    vecs[21] = V(1,1,0, 0,5, 0,0,  1,0, 0,0,0, 1,0,0,0,0,0);

    apply(vecs[0]);
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      apply(vecs[i]);
      #3;
      chk($sformatf("row%0d rdy", i),  32'(issue_rdy),         32'(vecs[i].rdy));
      chk($sformatf("row%0d aval", i), 32'(rob_alloc_req_val), 32'(vecs[i].aval));
      chk($sformatf("row%0d fval", i), 32'(rob_fill_val),      32'(vecs[i].fval));
      if (vecs[i].fval)
        chk($sformatf("row%0d fslot", i), 32'(rob_fill_slot), 32'(vecs[i].fslot));
      if (vecs[i].aval)
        chk($sformatf("row%0d preg", i), 32'(rob_alloc_req_preg), 32'(vecs[i].da));
      chk($sformatf("row%0d byp0", i), 32'(src0_byp), 32'(vecs[i].b0));
      chk($sformatf("row%0d byp1", i), 32'(src1_byp), 32'(vecs[i].b1));
      @(posedge clk); #1;
    end

    // Long op fill latency: expect the fill exactly LONG_LAT cycles after issue.
    issue(1, 20, 7);
    #3; chk("long issue rdy", 32'(issue_rdy), 32'd1);
    @(posedge clk); #1;
    idle();
    k = 1;
    while (k <= 10) begin
      #3;
      if (rob_fill_val) break;
      @(posedge clk); #1;
      k++;
    end
    chk("long fill latency", 32'(k), 32'd4);
    chk("long fill slot", 32'(rob_fill_slot), 32'd7);
    @(posedge clk); #1;

    // Three entries in flight, then reset drops them all.
    issue(1, 12, 8);  #3; chk("t6 issue0 rdy", 32'(issue_rdy), 32'd1); @(posedge clk); #1;
    issue(1, 14, 9);  #3; chk("t6 issue1 rdy", 32'(issue_rdy), 32'd1); @(posedge clk); #1;
    issue(0, 13, 10); #3; chk("t6 issue2 rdy", 32'(issue_rdy), 32'd1); @(posedge clk); #1;
    apply(V(0,1,0, 12,13, 0,0, 1,0, 0,0,0, 0,0,0,0,0,0));
    #3;
    chk("t6 rst fval", 32'(rob_fill_val), 32'd0);
    chk("t6 rst rdy",  32'(issue_rdy),    32'd0);
    chk("t6 rst aval", 32'(rob_alloc_req_val), 32'd0);
    @(posedge clk); #1;
    idle();
    for (int c = 0; c < 6; c++) begin
      #3;
      chk($sformatf("t6 post fval c%0d", c), 32'(rob_fill_val), 32'd0);
      @(posedge clk); #1;
    end
    for (int r = 1; r < 32; r++) begin
      apply(V(1,1,0, r,r, 0,0, 1,0, 0,0,0, 0,0,0,0,0,0));
      #1;
      chk($sformatf("t6 src r%0d rdy", r), 32'(issue_rdy), 32'd1);
      chk($sformatf("t6 src r%0d byp", r), 32'({src0_byp, src1_byp}), 32'd0);
    end
    idle();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
